// File: rtl/seq_lock_ctrl.sv
// seq_lock_ctrl: two-button code-entry lock controller.
// Turns rising edges of the P1/P2 button levels into symbols and compares them
// with a programmable code register. Repeated failures trigger a timed lockout,
// and a correct entry produces a fixed-length unlock strobe.
// Optional build macro SEQ_LOCK_TIMEOUT_EN adds an inactivity timeout that
// abandons a partially entered code.
module seq_lock_ctrl #(
    parameter int                     CODE_LEN    = 4,
    parameter logic [CODE_LEN-1:0]    CODE        = 4'b1101,
    parameter int                     MAX_FAIL    = 3,
    parameter int                     HOLD_CYCLES = 8,
    parameter int                     LOCK_CYCLES = 32
`ifdef SEQ_LOCK_TIMEOUT_EN
    ,
    parameter int                     TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              p1,
    input  logic                              p2,
    input  logic                              prog_we,
    input  logic [CODE_LEN-1:0]               prog_code,
    output logic                              unlock,
    output logic                              locked_out,
    output logic                              busy,
    output logic [$clog2(CODE_LEN+1)-1:0]     entry_idx,
    output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

    localparam int IW   = $clog2(CODE_LEN + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);
    localparam int TMAX = (HOLD_CYCLES > LOCK_CYCLES) ? HOLD_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
`ifdef SEQ_LOCK_TIMEOUT_EN
    localparam int GW   = $clog2(TIMEOUT_CYCLES + 1);
`endif

    typedef enum logic [1:0] {IDLE, ENTER, UNLOCK, LOCKOUT} state_t;

    state_t                state_q, state_d;
    logic                  p1_q, p2_q;
    logic [CODE_LEN-1:0]   code_q, code_d;
    logic [IW-1:0]         entryIdx_q, entryIdx_d;
    logic [FW-1:0]         failCnt_q, failCnt_d;
    logic                  err_q, err_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  unlock_q, lockedOut_q, busy_q;
`ifdef SEQ_LOCK_TIMEOUT_EN
    logic [GW-1:0]         gap_q, gap_d;
`endif

    logic ev1, ev2, symEv, codeBit, mismatch;
    logic finish, errFinal;

    // A press in both buttons at once is an invalid symbol and never matches.
    assign ev1      = p1 & ~p1_q;
    assign ev2      = p2 & ~p2_q;
    assign symEv    = ev1 | ev2;
    assign codeBit  = |(code_q & (CODE_LEN'(1) << entryIdx_q));
    assign mismatch = (ev1 & ev2) | (ev1 != codeBit);

    // Next-state and counter logic; an attempt that consumes its final symbol raises finish.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        entryIdx_d = entryIdx_q;
        failCnt_d  = failCnt_q;
        err_d      = err_q;
        timer_d    = timer_q;
        finish     = 1'b0;
        errFinal   = 1'b0;
`ifdef SEQ_LOCK_TIMEOUT_EN
        gap_d      = gap_q;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (symEv) begin
`ifdef SEQ_LOCK_TIMEOUT_EN
                    gap_d = '0;
`endif
                    if (CODE_LEN == 1) begin
                        finish   = 1'b1;
                        errFinal = mismatch;
                    end else begin
                        state_d    = ENTER;
                        entryIdx_d = IW'(1);
                        err_d      = mismatch;
                    end
                end else if (prog_we) begin
                    code_d = prog_code;
                end
            end
            ENTER: begin
                if (symEv) begin
`ifdef SEQ_LOCK_TIMEOUT_EN
                    gap_d = '0;
`endif
                    if (entryIdx_q == IW'(CODE_LEN - 1)) begin
                        finish   = 1'b1;
                        errFinal = err_q | mismatch;
                    end else begin
                        entryIdx_d = entryIdx_q + IW'(1);
                        err_d      = err_q | mismatch;
                    end
                end
`ifdef SEQ_LOCK_TIMEOUT_EN
                else if (gap_q == GW'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = IDLE;
                    entryIdx_d = '0;
                    err_d      = 1'b0;
                    gap_d      = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
`endif
            end
            UNLOCK: begin
                if (timer_q == TW'(HOLD_CYCLES - 1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            LOCKOUT: begin
                if (timer_q == TW'(LOCK_CYCLES - 1)) begin
                    state_d   = IDLE;
                    timer_d   = '0;
                    failCnt_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            entryIdx_d = '0;
            err_d      = 1'b0;
            timer_d    = '0;
            if (!errFinal) begin
                state_d   = UNLOCK;
                failCnt_d = '0;
            end else if (int'(failCnt_q) + 1 == MAX_FAIL) begin
                state_d   = LOCKOUT;
                failCnt_d = FW'(MAX_FAIL);
            end else begin
                state_d   = IDLE;
                failCnt_d = failCnt_q + FW'(1);
            end
        end
    end

    // State, counters and registered Moore outputs; previous button levels reset high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            p1_q        <= 1'b1;
            p2_q        <= 1'b1;
            code_q      <= CODE;
            entryIdx_q  <= '0;
            failCnt_q   <= '0;
            err_q       <= 1'b0;
            timer_q     <= '0;
            unlock_q    <= 1'b0;
            lockedOut_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SEQ_LOCK_TIMEOUT_EN
            gap_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            p1_q        <= p1;
            p2_q        <= p2;
            code_q      <= code_d;
            entryIdx_q  <= entryIdx_d;
            failCnt_q   <= failCnt_d;
            err_q       <= err_d;
            timer_q     <= timer_d;
            unlock_q    <= (state_d == UNLOCK);
            lockedOut_q <= (state_d == LOCKOUT);
            busy_q      <= (state_d != IDLE);
`ifdef SEQ_LOCK_TIMEOUT_EN
            gap_q       <= gap_d;
`endif
        end
    end

    assign unlock     = unlock_q;
    assign locked_out = lockedOut_q;
    assign busy       = busy_q;
    assign entry_idx  = entryIdx_q;
    assign fail_cnt   = failCnt_q;

endmodule

// File: tb/tb_seq_lock_ctrl.sv
// Testbench for seq_lock_ctrl: a table of directed vectors for normal entry,
// failed attempts and lockout, followed by hand-written corner-case sequences.
module tb_seq_lock_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       p1, p2, prog_we;
    logic [3:0] prog_code;
    logic       unlock, locked_out, busy;
    logic [2:0] entry_idx;
    logic [1:0] fail_cnt;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic       p1v, p2v, we;
        logic [3:0] code;
        int         n;
        logic       u, l, b;
        logic [2:0] idx;
        logic [1:0] fc;
    } vec_t;

    vec_t vecs[$];

    seq_lock_ctrl dut (
        .clk(clk), .reset(reset), .p1(p1), .p2(p2),
        .prog_we(prog_we), .prog_code(prog_code),
        .unlock(unlock), .locked_out(locked_out), .busy(busy),
        .entry_idx(entry_idx), .fail_cnt(fail_cnt)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic a, input logic b, input logic we, input logic [3:0] c);
        p1 = a; p2 = b; prog_we = we; prog_code = c;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic u, input logic l, input logic b,
                               input logic [2:0] idx, input logic [1:0] fc);
        vecCount++;
        if (unlock !== u || locked_out !== l || busy !== b || entry_idx !== idx || fail_cnt !== fc) begin
            missCount++;
            $display("[TB] FAIL %s: got unlock=%0b locked_out=%0b busy=%0b entry_idx=%0d fail_cnt=%0d, expected %0b %0b %0b %0d %0d",
                     name, unlock, locked_out, busy, entry_idx, fail_cnt, u, l, b, idx, fc);
        end
    endtask

    // One idle cycle followed by a one-cycle press; the sample is right after the press edge.
    task automatic pressSym(input logic sym);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(sym, ~sym, 1'b0, 4'b0000);
    endtask

    task automatic doReset();
        reset = 1'b1;
        p1 = 1'b0; p2 = 1'b0; prog_we = 1'b0; prog_code = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic addVec(input logic a, input logic b, input logic we, input logic [3:0] c, input int n,
                          input logic u, input logic l, input logic bz, input logic [2:0] idx, input logic [1:0] fc);
        vec_t v;
        v.p1v = a; v.p2v = b; v.we = we; v.code = c; v.n = n;
        v.u = u; v.l = l; v.b = bz; v.idx = idx; v.fc = fc;
        vecs.push_back(v);
    endtask

    // Correct entry of the reset code 1101 (P1,P2,P1,P1) and the full unlock window.
    task automatic addUnlockAttempt();
        logic [3:0] syms;
        syms = 4'b1101;
        for (int s = 0; s < 4; s++) begin
            if (s < 3) begin
                addVec(syms[s], ~syms[s], 1'b0, 4'b0000, 1, 1'b0, 1'b0, 1'b1, 3'(s + 1), 2'd0);
                addVec(1'b0, 1'b0, 1'b0, 4'b0000, 1, 1'b0, 1'b0, 1'b1, 3'(s + 1), 2'd0);
            end else begin
                addVec(syms[s], ~syms[s], 1'b0, 4'b0000, 1, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0);
                addVec(1'b0, 1'b0, 1'b0, 4'b0000, 7, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0);
                addVec(1'b0, 1'b0, 1'b0, 4'b0000, 1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
            end
        end
    endtask

    // Table construction, table replay, then the multi-cycle corner cases.
    initial begin
        addVec(1'b0, 1'b0, 1'b0, 4'b0000, 2, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        addUnlockAttempt();
        for (int a = 0; a < 3; a++) begin
            for (int s = 0; s < 4; s++) begin
                if (s < 3) begin
                    addVec(1'b0, 1'b1, 1'b0, 4'b0000, 1, 1'b0, 1'b0, 1'b1, 3'(s + 1), 2'(a));
                    addVec(1'b0, 1'b0, 1'b0, 4'b0000, 1, 1'b0, 1'b0, 1'b1, 3'(s + 1), 2'(a));
                end else if (a < 2) begin
                    addVec(1'b0, 1'b1, 1'b0, 4'b0000, 1, 1'b0, 1'b0, 1'b0, 3'd0, 2'(a + 1));
                    addVec(1'b0, 1'b0, 1'b0, 4'b0000, 1, 1'b0, 1'b0, 1'b0, 3'd0, 2'(a + 1));
                end else begin
                    addVec(1'b0, 1'b1, 1'b0, 4'b0000, 1, 1'b0, 1'b1, 1'b1, 3'd0, 2'd3);
                end
            end
        end
        addVec(1'b0, 1'b0, 1'b0, 4'b0000, 1,  1'b0, 1'b1, 1'b1, 3'd0, 2'd3);
        addVec(1'b1, 1'b0, 1'b1, 4'b0000, 1,  1'b0, 1'b1, 1'b1, 3'd0, 2'd3);
        addVec(1'b0, 1'b0, 1'b0, 4'b0000, 1,  1'b0, 1'b1, 1'b1, 3'd0, 2'd3);
        addVec(1'b0, 1'b1, 1'b0, 4'b0000, 1,  1'b0, 1'b1, 1'b1, 3'd0, 2'd3);
        addVec(1'b0, 1'b0, 1'b0, 4'b0000, 27, 1'b0, 1'b1, 1'b1, 3'd0, 2'd3);
        addVec(1'b0, 1'b0, 1'b0, 4'b0000, 1,  1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        addUnlockAttempt();

        $display("[TB] reset and table replay");
        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].n; r++) begin
                applyStimulus(vecs[i].p1v, vecs[i].p2v, vecs[i].we, vecs[i].code);
                checkOutput($sformatf("vec%0d.%0d", i, r), vecs[i].u, vecs[i].l, vecs[i].b, vecs[i].idx, vecs[i].fc);
            end
        end

        $display("[TB] button held through reset, double press");
        reset = 1'b1; p1 = 1'b1; p2 = 1'b0; prog_we = 1'b0; prog_code = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("held_p1_no_event", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
        checkOutput("double_press_first", 1'b0, 1'b0, 1'b1, 3'd1, 2'd0);
        pressSym(1'b0);
        pressSym(1'b1);
        pressSym(1'b1);
        checkOutput("double_press_fails", 1'b0, 1'b0, 1'b0, 3'd0, 2'd1);

        $display("[TB] code programming");
        doReset();
        checkOutput("reset_state", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
        for (int k = 0; k < 4; k++) pressSym(1'b0);
        checkOutput("prog_0000_unlock", 1'b1, 1'b0, 1'b1, 3'd0, 2'd0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("unlock_ends", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        pressSym(1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b1111);
        checkOutput("prog_in_enter", 1'b0, 1'b0, 1'b1, 3'd1, 2'd0);
        for (int k = 0; k < 3; k++) pressSym(1'b0);
        checkOutput("prog_in_enter_ignored", 1'b1, 1'b0, 1'b1, 3'd0, 2'd0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'b1111);
        checkOutput("prog_with_event", 1'b0, 1'b0, 1'b1, 3'd1, 2'd0);
        for (int k = 0; k < 3; k++) pressSym(1'b0);
        checkOutput("prog_with_event_ignored", 1'b1, 1'b0, 1'b1, 3'd0, 2'd0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);

        $display("[TB] asynchronous reset mid-ENTER and mid-UNLOCK");
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
        pressSym(1'b0);
        pressSym(1'b0);
        checkOutput("enter_idx2", 1'b0, 1'b0, 1'b1, 3'd2, 2'd0);
        #2 reset = 1'b1;
        #1 checkOutput("reset_mid_enter", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        pressSym(1'b1);
        pressSym(1'b0);
        pressSym(1'b1);
        pressSym(1'b1);
        checkOutput("code_restored_unlock", 1'b1, 1'b0, 1'b1, 3'd0, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        #2 reset = 1'b1;
        #1 checkOutput("reset_mid_unlock", 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] partial entry gap");
        for (int k = 0; k < 4; k++) pressSym(1'b0);
        checkOutput("one_failure", 1'b0, 1'b0, 1'b0, 3'd0, 2'd1);
        pressSym(1'b1);
        checkOutput("partial_start", 1'b0, 1'b0, 1'b1, 3'd1, 2'd1);
`ifdef SEQ_LOCK_TIMEOUT_EN
        repeat (63) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("before_timeout", 1'b0, 1'b0, 1'b1, 3'd1, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("after_timeout", 1'b0, 1'b0, 1'b0, 3'd0, 2'd1);
`else
        repeat (99) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("no_timeout_cycle100", 1'b0, 1'b0, 1'b1, 3'd1, 2'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
